// File: rtl/cpu_fetch_unit.sv
// Prefetching instruction-fetch stage: sequential fetch with wait-request handling,
// a DEPTH-entry {pc,instr} FIFO toward decode, and redirect flush.
module cpu_fetch_unit #(
    parameter int                ADDR_W   = 16,
    parameter int                DATA_W   = 16,
    parameter int                DEPTH    = 4,
    parameter int                PC_INC   = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic [ADDR_W-1:0]          o_pc_addr,
    output logic                       o_pc_rd,
    input  logic                       i_pc_waitreq,
    input  logic [DATA_W-1:0]          i_pc_rddata,
    output logic                       o_ir_valid,
    input  logic                       i_ir_ready,
    output logic [DATA_W-1:0]          o_ir,
    output logic [ADDR_W-1:0]          o_ir_pc,
    input  logic                       i_redirect,
    input  logic [ADDR_W-1:0]          i_redirect_pc,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0] fetch_pc;
    logic              inflight;
    logic [ADDR_W-1:0] inflight_pc;

    logic [ADDR_W-1:0] fifo_pc [DEPTH];
    logic [DATA_W-1:0] fifo_ir [DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [CW-1:0]     count;

    logic credit_ok;
    logic accept;
    logic push;
    logic pop;

    // In-flight word reserves a slot so the FIFO can never overflow; pops are not credited.
    assign credit_ok  = ({1'b0, count} + {{CW{1'b0}}, inflight}) < (CW+1)'(DEPTH);
    assign o_pc_rd    = !reset && !i_redirect && credit_ok;
    assign o_pc_addr  = fetch_pc;
    assign accept     = o_pc_rd && !i_pc_waitreq;

    assign o_ir_valid = !reset && (count != '0) && !i_redirect;
    assign o_ir       = fifo_ir[rd_ptr];
    assign o_ir_pc    = fifo_pc[rd_ptr];
    assign o_count    = count;

    assign push = inflight && !i_redirect;
    assign pop  = o_ir_valid && i_ir_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= RESET_PC;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
        end else if (i_redirect) begin
            fetch_pc <= i_redirect_pc;
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            assert (!(push && count == CW'(DEPTH)));
            assert (!(pop && count == '0));
            inflight <= accept;
            if (accept) begin
                fetch_pc    <= fetch_pc + ADDR_W'(PC_INC);
                inflight_pc <= fetch_pc;
            end
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read once count says they are valid.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            fifo_pc[wr_ptr] <= inflight_pc;
            fifo_ir[wr_ptr] <= i_pc_rddata;
        end
    end

endmodule

// File: tb/tb_cpu_fetch_unit.sv
// Directed bench for cpu_fetch_unit; memory returns address ^ 16'hA5A5 one cycle after acceptance.
module tb_cpu_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] o_pc_addr;
    logic        o_pc_rd;
    logic        i_pc_waitreq;
    logic [15:0] i_pc_rddata;
    logic        o_ir_valid;
    logic        i_ir_ready;
    logic [15:0] o_ir;
    logic [15:0] o_ir_pc;
    logic        i_redirect;
    logic [15:0] i_redirect_pc;
    logic [2:0]  o_count;

    int checks = 0;
    int errors = 0;
    int acc_cnt;

    cpu_fetch_unit #(
        .ADDR_W(16), .DATA_W(16), .DEPTH(4), .PC_INC(2), .RESET_PC(16'h0000)
    ) dut (
        .clk(clk),
        .reset(reset),
        .o_pc_addr(o_pc_addr),
        .o_pc_rd(o_pc_rd),
        .i_pc_waitreq(i_pc_waitreq),
        .i_pc_rddata(i_pc_rddata),
        .o_ir_valid(o_ir_valid),
        .i_ir_ready(i_ir_ready),
        .o_ir(o_ir),
        .o_ir_pc(o_ir_pc),
        .i_redirect(i_redirect),
        .i_redirect_pc(i_redirect_pc),
        .o_count(o_count)
    );

    always #5 clk = ~clk;

    // Memory model; non-accepted cycles return junk so stale pushes are visible.
    always @(posedge clk) begin
        if (o_pc_rd && !i_pc_waitreq) i_pc_rddata <= o_pc_addr ^ 16'hA5A5;
        else                          i_pc_rddata <= 16'hDEAD;
    end

    always @(posedge clk) begin
        if (reset)                         acc_cnt <= 0;
        else if (o_pc_rd && !i_pc_waitreq) acc_cnt <= acc_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset(input bit check_state);
        reset         = 1'b1;
        i_ir_ready    = 1'b0;
        i_pc_waitreq  = 1'b0;
        i_redirect    = 1'b0;
        i_redirect_pc = 16'h0000;
        cyc();
        cyc();
        settle();
        if (check_state) begin
            check("rst_pc_rd", 32'(o_pc_rd), 32'd0);
            check("rst_valid", 32'(o_ir_valid), 32'd0);
            check("rst_count", 32'(o_count), 32'd0);
            check("rst_addr", 32'(o_pc_addr), 32'h0000);
        end
        reset = 1'b0;
    endtask

    // Requires i_ir_ready=1; every delivered word must continue the sequence from start.
    task automatic drain_check(input logic [15:0] start, input int n, input int budget);
        logic [15:0] exp_pc;
        int got;
        int cycles;
        exp_pc = start;
        got    = 0;
        cycles = 0;
        while (got < n && cycles < budget) begin
            settle();
            if (o_ir_valid) begin
                check("drain_pc", 32'(o_ir_pc), 32'(exp_pc));
                check("drain_ir", 32'(o_ir), 32'(exp_pc ^ 16'hA5A5));
                exp_pc = exp_pc + 16'd2;
                got++;
            end
            cyc();
            cycles++;
        end
        check("drain_count", 32'(got), 32'(n));
    endtask

    initial begin
        logic [15:0] exp_pc;
        int          n0a;
        bit          exp_valid;

        // 1: streaming, first word two cycles after first request
        do_reset(1'b1);
        i_ir_ready = 1'b1;
        settle();
        check("t1_c0_rd", 32'(o_pc_rd), 32'd1);
        check("t1_c0_addr", 32'(o_pc_addr), 32'h0000);
        cyc();
        settle();
        check("t1_c1_addr", 32'(o_pc_addr), 32'h0002);
        check("t1_c1_valid", 32'(o_ir_valid), 32'd0);
        cyc();
        for (int k = 0; k < 6; k++) begin
            settle();
            check("t1_valid", 32'(o_ir_valid), 32'd1);
            check("t1_pc", 32'(o_ir_pc), 32'(2 * k));
            check("t1_ir", 32'(o_ir), 32'((16'(2 * k)) ^ 16'hA5A5));
            check("t1_count", 32'(o_count), 32'd1);
            cyc();
        end

        // 2: decode stalled from reset fills exactly DEPTH entries
        do_reset(1'b0);
        for (int k = 0; k < 6; k++) cyc();
        settle();
        check("t2_accepts", 32'(acc_cnt), 32'd4);
        check("t2_rd", 32'(o_pc_rd), 32'd0);
        check("t2_count", 32'(o_count), 32'd4);
        check("t2_addr", 32'(o_pc_addr), 32'h0008);
        i_ir_ready = 1'b1;
        drain_check(16'h0000, 5, 12);

        // 3: waitreq held for three cycles at 0x000A
        do_reset(1'b0);
        i_ir_ready = 1'b1;
        exp_pc = 16'h0000;
        n0a    = 0;
        for (int n = 0; n < 14; n++) begin
            i_pc_waitreq = (n >= 5 && n <= 7);
            settle();
            if (n >= 5 && n <= 7) begin
                check("t3_hold_addr", 32'(o_pc_addr), 32'h000A);
                check("t3_hold_rd", 32'(o_pc_rd), 32'd1);
            end
            exp_valid = (n >= 2 && n <= 6) || (n >= 10);
            check("t3_valid", 32'(o_ir_valid), 32'(exp_valid));
            if (o_ir_valid) begin
                check("t3_pc", 32'(o_ir_pc), 32'(exp_pc));
                if (o_ir_pc == 16'h000A) n0a++;
                exp_pc = exp_pc + 16'd2;
            end
            cyc();
        end
        i_pc_waitreq = 1'b0;
        check("t3_once_0a", 32'(n0a), 32'd1);
        check("t3_next_pc", 32'(exp_pc), 32'h0012);

        // 4: redirect with three buffered and one in flight
        do_reset(1'b0);
        for (int k = 0; k < 4; k++) cyc();
        settle();
        check("t4_pre_count", 32'(o_count), 32'd3);
        i_redirect    = 1'b1;
        i_redirect_pc = 16'h0100;
        settle();
        check("t4_r_valid", 32'(o_ir_valid), 32'd0);
        check("t4_r_rd", 32'(o_pc_rd), 32'd0);
        cyc();
        i_redirect = 1'b0;
        i_ir_ready = 1'b1;
        settle();
        check("t4_r1_count", 32'(o_count), 32'd0);
        check("t4_r1_rd", 32'(o_pc_rd), 32'd1);
        check("t4_r1_addr", 32'(o_pc_addr), 32'h0100);
        check("t4_r1_valid", 32'(o_ir_valid), 32'd0);
        drain_check(16'h0100, 4, 20);

        // 5: redirect against a pop and an in-flight push, then back-to-back redirect
        do_reset(1'b0);
        i_ir_ready = 1'b1;
        for (int k = 0; k < 3; k++) cyc();
        settle();
        check("t5_pre_valid", 32'(o_ir_valid), 32'd1);
        check("t5_pre_count", 32'(o_count), 32'd1);
        i_redirect    = 1'b1;
        i_redirect_pc = 16'h0300;
        settle();
        check("t5_r_valid", 32'(o_ir_valid), 32'd0);
        check("t5_r_rd", 32'(o_pc_rd), 32'd0);
        cyc();
        i_redirect_pc = 16'h0200;
        settle();
        check("t5_r2_rd", 32'(o_pc_rd), 32'd0);
        cyc();
        i_redirect = 1'b0;
        settle();
        check("t5_r1_count", 32'(o_count), 32'd0);
        check("t5_r1_addr", 32'(o_pc_addr), 32'h0200);
        check("t5_r1_rd", 32'(o_pc_rd), 32'd1);
        drain_check(16'h0200, 3, 20);

        // 6: reset mid-stream, then address wrap
        do_reset(1'b0);
        for (int k = 0; k < 4; k++) cyc();
        settle();
        check("t6_pre_count", 32'(o_count), 32'd3);
        reset = 1'b1;
        cyc();
        settle();
        check("t6_rst_count", 32'(o_count), 32'd0);
        check("t6_rst_valid", 32'(o_ir_valid), 32'd0);
        check("t6_rst_rd", 32'(o_pc_rd), 32'd0);
        check("t6_rst_addr", 32'(o_pc_addr), 32'h0000);
        reset      = 1'b0;
        i_ir_ready = 1'b1;
        settle();
        check("t6_resume_addr", 32'(o_pc_addr), 32'h0000);
        check("t6_resume_rd", 32'(o_pc_rd), 32'd1);
        drain_check(16'h0000, 2, 20);
        i_redirect    = 1'b1;
        i_redirect_pc = 16'hFFFC;
        settle();
        cyc();
        i_redirect = 1'b0;
        drain_check(16'hFFFC, 4, 20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
